// File: rtl/tx_packetizer_pkg.sv
// Shared types and helpers for the transmit framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: framer state enum, default sync byte, checksum step helper.
package tx_packetizer_pkg;

   typedef enum logic [2:0] {
      ST_FILL = 3'd0,
      ST_HDR  = 3'd1,
      ST_LEN  = 3'd2,
      ST_DATA = 3'd3,
      ST_CSUM = 3'd4
   } state_e;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Running checksum is a plain XOR over LEN and every payload byte.
   function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/pkt_buf.sv
// Payload store for one packet: DEPTH x 8 register file, one write port, one read port.
// Latency: write lands at the next rising edge; read is combinational from rd_addr.
// Backpressure: none; the caller decides when wr_en is allowed.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr/rd_data read port.
module pkt_buf
   import tx_packetizer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // Storage is deliberately not reset: stale entries are never read because
   // the framer only reads indices below the current packet length.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/tx_packetizer.sv
// Store-and-forward framer: buffers one packet, then emits SYNC, LEN, payload
// (and an XOR checksum when TX_CHECKSUM_EN is defined) one byte per transmitter handshake.
// Latency: sync strobe registered one cycle after the HDR state is entered with tx_busy low.
// Backpressure: in_ready is high only while filling; emission stalls while tx_busy is high.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_last/in_ready producer side;
//        tx_data/tx_new_data/tx_busy transmitter side; pkt_busy and ovf_pulse status.
// Build option: define TX_CHECKSUM_EN to append the checksum byte.
module tx_packetizer
   import tx_packetizer_pkg::*;
#(
   parameter int          DEPTH     = 16,
   parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [7:0] tx_data,
   output logic       tx_new_data,
   input  logic       tx_busy,
   output logic       pkt_busy,
   output logic       ovf_pulse
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   rd_idx_q, rd_idx_d;
   logic            wait_q, wait_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_new_data_q, tx_new_data_d;
   logic            ovf_pulse_q, ovf_pulse_d;
`ifdef TX_CHECKSUM_EN
   logic [7:0]      csum_q, csum_d;
`endif

   logic            emit_ok;
   logic            wr_en;
   logic [7:0]      rd_data;

   pkt_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_pkt_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (cnt_q[AW-1:0]),
      .wr_data (in_data),
      .rd_addr (rd_idx_q[AW-1:0]),
      .rd_data (rd_data)
   );

   // wait_q covers the one cycle between our strobe and the transmitter's
   // registered busy rising, so a second byte cannot slip in before acceptance.
   assign emit_ok = !tx_busy && !wait_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rd_idx_d      = rd_idx_q;
      tx_data_d     = tx_data_q;
      tx_new_data_d = 1'b0;
      ovf_pulse_d   = 1'b0;
      wr_en         = 1'b0;
`ifdef TX_CHECKSUM_EN
      csum_d        = csum_q;
`endif

      case (state_q)
         ST_FILL: begin
            if (in_valid) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + CW'(1);
`ifdef TX_CHECKSUM_EN
               csum_d = csum_step(csum_q, in_data);
`endif
               if (in_last) begin
                  state_d = ST_HDR;
               end else if (cnt_q == CW'(DEPTH - 1)) begin
                  // Buffer full without a last marker: close the packet here.
                  state_d     = ST_HDR;
                  ovf_pulse_d = 1'b1;
               end
            end
         end

         ST_HDR: begin
            if (emit_ok) begin
               tx_data_d     = SYNC_BYTE;
               tx_new_data_d = 1'b1;
               state_d       = ST_LEN;
            end
         end

         ST_LEN: begin
            if (emit_ok) begin
               tx_data_d     = 8'(cnt_q);
               tx_new_data_d = 1'b1;
               state_d       = ST_DATA;
            end
         end

         ST_DATA: begin
            if (emit_ok) begin
               tx_data_d     = rd_data;
               tx_new_data_d = 1'b1;
               rd_idx_d      = rd_idx_q + CW'(1);
               if (rd_idx_q == cnt_q - CW'(1)) begin
`ifdef TX_CHECKSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_FILL;
`endif
               end
            end
         end

`ifdef TX_CHECKSUM_EN
         ST_CSUM: begin
            if (emit_ok) begin
               // Accumulator already holds the payload XOR; fold LEN in last.
               tx_data_d     = csum_step(csum_q, 8'(cnt_q));
               tx_new_data_d = 1'b1;
               state_d       = ST_FILL;
            end
         end
`endif

         default: begin
            state_d = ST_FILL;
         end
      endcase

      // Returning to FILL starts a fresh packet.
      if ((state_d == ST_FILL) && (state_q != ST_FILL)) begin
         cnt_d    = '0;
         rd_idx_d = '0;
`ifdef TX_CHECKSUM_EN
         csum_d   = '0;
`endif
      end

      wait_d = tx_new_data_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_FILL;
         cnt_q         <= '0;
         rd_idx_q      <= '0;
         wait_q        <= 1'b0;
         tx_data_q     <= 8'h00;
         tx_new_data_q <= 1'b0;
         ovf_pulse_q   <= 1'b0;
`ifdef TX_CHECKSUM_EN
         csum_q        <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rd_idx_q      <= rd_idx_d;
         wait_q        <= wait_d;
         tx_data_q     <= tx_data_d;
         tx_new_data_q <= tx_new_data_d;
         ovf_pulse_q   <= ovf_pulse_d;
`ifdef TX_CHECKSUM_EN
         csum_q        <= csum_d;
`endif
      end
   end

   assign in_ready    = (state_q == ST_FILL);
   assign pkt_busy    = (state_q != ST_FILL);
   assign tx_data     = tx_data_q;
   assign tx_new_data = tx_new_data_q;
   assign ovf_pulse   = ovf_pulse_q;

endmodule

// File: tb/tb_tx_packetizer.sv
// Bench for tx_packetizer: directed scenarios plus randomized packets, scored
// against a frame-level reference queue and a simple 10-cycle transmitter model.
module tb_tx_packetizer;

   localparam int         DEPTH = 16;
   localparam logic [7:0] SYNC  = 8'hA5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic [7:0] tx_data;
   logic       tx_new_data;
   logic       tx_busy = 1'b0;
   logic       pkt_busy;
   logic       ovf_pulse;

   tx_packetizer #(.DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .tx_data     (tx_data),
      .tx_new_data (tx_new_data),
      .tx_busy     (tx_busy),
      .pkt_busy    (pkt_busy),
      .ovf_pulse   (ovf_pulse)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [7:0] exp_q[$];      // bytes the transmitter must still receive, in order
   logic [7:0] cur_pkt[$];    // bytes accepted for the packet being filled
   int         exp_ovf_cnt = 0;
   int         ovf_cnt = 0;
   int         nstrobe = 0;
   int         cyc = 0;
   int         last_strobe_cyc = 0;
   int         acc_cyc = 0;
   int         tx_left = 0;
   bit         force_busy = 1'b0;
   logic [7:0] last_data = 8'h00;
   bit         prev_strobe = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor + transmitter model: samples 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         check_eq("rst_strobe", tx_new_data, 0);
         check_eq("rst_tx_data", tx_data, 0);
         last_data = 8'h00;
      end else if (tx_new_data) begin
         check_eq("strobe_gap", prev_strobe, 0);
         check_eq("strobe_while_busy", tx_busy, 0);
         check_eq("frame_pending", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check_eq("frame_byte", tx_data, exp_q.pop_front());
         last_data = tx_data;
         nstrobe++;
         last_strobe_cyc = cyc;
      end else begin
         check_eq("tx_data_hold", tx_data, last_data);
      end
      if (ovf_pulse) ovf_cnt++;
      prev_strobe = tx_new_data;
      if (tx_new_data) tx_left = 10;
      else if (tx_left > 0) tx_left--;
      tx_busy = force_busy || (tx_left > 0);
   end

   function automatic void close_pkt();
      logic [7:0] len;
      logic [7:0] x;
      len = 8'(cur_pkt.size());
      exp_q.push_back(SYNC);
      exp_q.push_back(len);
      x = len;
      foreach (cur_pkt[i]) begin
         exp_q.push_back(cur_pkt[i]);
         x = x ^ cur_pkt[i];
      end
`ifdef TX_CHECKSUM_EN
      exp_q.push_back(x);
`endif
      cur_pkt.delete();
   endfunction

   task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
      int guard;
      bit closed;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      guard = 0;
      while (!in_ready && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         check_eq("accept_timeout", guard, 0);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #2;
      acc_cyc = cyc;
      check_eq("accept_in_fill_only", exp_q.size(), 0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      cur_pkt.push_back(d);
      closed = last || (cur_pkt.size() == DEPTH);
      if (closed) begin
         close_pkt();
         if (!last) exp_ovf_cnt++;
         check_eq("ovf_pulse", ovf_pulse, !last);
         check_eq("in_ready_closed", in_ready, 0);
         check_eq("pkt_busy_closed", pkt_busy, 1);
         if (!tx_busy) begin
            @(posedge clk);
            #2;
            check_eq("sync_latency", tx_new_data, 1);
         end
      end else begin
         check_eq("ovf_quiet", ovf_pulse, 0);
      end
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (!(exp_q.size() == 0 && in_ready && !tx_busy) && guard < 4000) begin
         @(negedge clk);
         guard++;
      end
      check_eq("frame_done", exp_q.size(), 0);
      check_eq("idle_in_ready", in_ready, 1);
      check_eq("idle_pkt_busy", pkt_busy, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #2;
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_pkt_busy", pkt_busy, 0);
      check_eq("rst_new_data", tx_new_data, 0);
      exp_q.delete();
      cur_pkt.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int snap;
      int guard;
      int len;
      bit nolast;

      repeat (3) @(posedge clk);
      #2;
      check_eq("reset_new_data", tx_new_data, 0);
      check_eq("reset_tx_data", tx_data, 0);
      check_eq("reset_ovf", ovf_pulse, 0);
      check_eq("reset_in_ready", in_ready, 1);
      check_eq("reset_pkt_busy", pkt_busy, 0);
      @(negedge clk);
      rst = 1'b0;

      // Three-byte packet
      send_byte(8'h11, 1'b0, 0);
      send_byte(8'h22, 1'b0, 0);
      send_byte(8'h33, 1'b1, 0);
      wait_idle();

      // Single zero byte
      send_byte(8'h00, 1'b1, 0);
      wait_idle();

      // Full buffer with no last marker -> forced close
      for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0, 0);
      wait_idle();
      check_eq("ovf_count_directed", ovf_cnt, 1);

      // Transmitter busy forced high after the sync strobe
      snap = nstrobe;
      send_byte(8'h44, 1'b0, 0);
      send_byte(8'h55, 1'b0, 0);
      send_byte(8'h66, 1'b1, 0);
      guard = 0;
      while (nstrobe == snap && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check_eq("sync_seen", nstrobe, snap + 1);
      force_busy = 1'b1;
      snap = nstrobe;
      repeat (200) @(negedge clk);
      check_eq("stall_no_strobe", nstrobe, snap);
      force_busy = 1'b0;
      wait_idle();

      // Producer keeps offering the next packet while a frame is sent
      send_byte(8'hA1, 1'b0, 0);
      send_byte(8'hA2, 1'b1, 0);
      send_byte(8'hB0, 1'b1, 0);
      check_eq("first_fill_accept", acc_cyc - last_strobe_cyc, 1);
      wait_idle();

      // Reset in DATA after two payload strobes
      snap = nstrobe;
      for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), i == 4, 0);
      guard = 0;
      while (nstrobe < snap + 4 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      check_eq("reached_data", nstrobe, snap + 4);
      pulse_reset();
      snap = nstrobe;
      repeat (30) @(negedge clk);
      check_eq("no_strobe_after_rst", nstrobe, snap);
      wait_idle();
      send_byte(8'h7E, 1'b1, 0);
      wait_idle();

      // Reset wins over a simultaneous closing byte
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h99;
      in_last = 1'b1;
      @(posedge clk);
      #2;
      check_eq("prio_in_ready", in_ready, 1);
      check_eq("prio_pkt_busy", pkt_busy, 0);
      check_eq("prio_ovf", ovf_pulse, 0);
      in_valid = 1'b0;
      in_last = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      snap = nstrobe;
      repeat (10) @(negedge clk);
      check_eq("prio_no_frame", nstrobe, snap);

      // Randomized packets, some back-to-back, some forced-close
      for (int p = 0; p < 30; p++) begin
         len = $urandom_range(1, DEPTH);
         nolast = (len == DEPTH) && ($urandom_range(0, 1) == 1);
         for (int i = 0; i < len; i++)
            send_byte(8'($urandom_range(0, 255)), (i == len - 1) && !nolast, $urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) wait_idle();
      end
      wait_idle();
      check_eq("ovf_count_total", ovf_cnt, exp_ovf_cnt);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end

endmodule
